// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_pkg
//  Description : Shared LED-block definitions: mode encodings, the entry
//                pattern loaded when each mode is entered, and helpers for
//                mode sequencing.
//                LED patterns are active-low (0 = lit).
//  Revision    : 1.0  initial release
// ============================================================================
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'd0,
        MODE_WATER    = 2'd1,
        MODE_PINGPONG = 2'd2,
        MODE_BLINK    = 2'd3
    } led_mode_e;

    localparam logic [3:0] c_pat_off      = 4'b1111;
    localparam logic [3:0] c_pat_water    = 4'b1110;
    localparam logic [3:0] c_pat_pingpong = 4'b1110;
    localparam logic [3:0] c_pat_blink    = 4'b0000;

    function automatic led_mode_e next_mode(input led_mode_e m);
        case (m)
            MODE_OFF:      return MODE_WATER;
            MODE_WATER:    return MODE_PINGPONG;
            MODE_PINGPONG: return MODE_BLINK;
            default:       return MODE_OFF;
        endcase
    endfunction

    function automatic logic [3:0] entry_pattern(input led_mode_e m);
        case (m)
            MODE_WATER:    return c_pat_water;
            MODE_PINGPONG: return c_pat_pingpong;
            MODE_BLINK:    return c_pat_blink;
            default:       return c_pat_off;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : led_tick_gen
//  Description : Step timer. Counts 0..CNT_MAX while enabled and raises tick
//                during the cycle the count sits at CNT_MAX, then wraps.
//  Ports       : sys_clk   - clock (rising edge)
//                sys_rst_n - asynchronous active-low reset
//                clr       - synchronous clear to 0 (wins over en)
//                en        - count enable; holds the count when low
//                tick      - high in the terminal-count cycle while enabled
//  Revision    : 1.0  initial release
// ============================================================================
module led_tick_gen #(
    parameter int unsigned CNT_MAX = 24_999_999
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CW-1:0] c_cnt_max = CW'(CNT_MAX);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (r_cnt == c_cnt_max) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Gated by en so a frozen timer parked at CNT_MAX never fires.
    assign tick = en && (r_cnt == c_cnt_max);

endmodule
`default_nettype wire

// File: rtl/led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : led_pattern_ctrl
//  Description : Four-LED pattern controller. key_mode cycles through
//                OFF -> WATER -> PINGPONG -> BLINK; key_pause freezes and
//                resumes stepping. One pattern step per CNT_MAX+1 clocks.
//  Ports       : sys_clk   - clock (rising edge)
//                sys_rst_n - asynchronous active-low reset
//                key_mode  - one-cycle pulse, advance to next mode
//                key_pause - one-cycle pulse, toggle pause (ignored in OFF)
//                led_out   - LED drive, active-low, registered
//                mode      - current mode, registered
//                paused    - stepping frozen, registered
//  Revision    : 1.0  initial release
// ============================================================================
module led_pattern_ctrl #(
    parameter int unsigned CNT_MAX = 24_999_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key_mode,
    input  logic       key_pause,
    output logic [3:0] led_out,
    output logic [1:0] mode,
    output logic       paused
);

    import led_pkg::*;

    led_mode_e  r_mode,   w_mode_nxt;
    logic [3:0] r_led,    w_led_nxt;
    logic       r_paused, w_paused_nxt;
    logic [1:0] r_pos,    w_pos_nxt;
    logic       r_dir_up, w_dir_up_nxt;

    logic       w_tick;
    logic       w_pause_hit;
    logic       w_timer_clr;
    logic       w_timer_en;
    logic [1:0] w_pos_step;

    // A pause pulse that will be honoured; key_mode in the same cycle wins.
    assign w_pause_hit = key_pause && !key_mode && (r_mode != MODE_OFF);

    // The timer freezes on the edge that pauses and stays frozen on the edge
    // that resumes, so a paused step resumes with exactly the remaining count.
    assign w_timer_clr = key_mode || (r_mode == MODE_OFF);
    assign w_timer_en  = (r_mode != MODE_OFF) && !r_paused && !w_pause_hit;

    led_tick_gen #(
        .CNT_MAX (CNT_MAX)
    ) u_tick_gen (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr       (w_timer_clr),
        .en        (w_timer_en),
        .tick      (w_tick)
    );

    assign w_pos_step = r_dir_up ? (r_pos + 2'd1) : (r_pos - 2'd1);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_mode   <= MODE_OFF;
            r_led    <= c_pat_off;
            r_paused <= 1'b0;
            r_pos    <= 2'd0;
            r_dir_up <= 1'b1;
        end else begin
            r_mode   <= w_mode_nxt;
            r_led    <= w_led_nxt;
            r_paused <= w_paused_nxt;
            r_pos    <= w_pos_nxt;
            r_dir_up <= w_dir_up_nxt;
        end
    end

    always_comb begin
        w_mode_nxt   = r_mode;
        w_led_nxt    = r_led;
        w_paused_nxt = r_paused;
        w_pos_nxt    = r_pos;
        w_dir_up_nxt = r_dir_up;

        if (key_mode) begin
            // Mode change overrides any tick or pause in the same cycle.
            w_mode_nxt   = next_mode(r_mode);
            w_led_nxt    = entry_pattern(w_mode_nxt);
            w_paused_nxt = 1'b0;
            w_pos_nxt    = 2'd0;
            w_dir_up_nxt = 1'b1;
        end else begin
            if (w_pause_hit) begin
                w_paused_nxt = !r_paused;
            end
            if (w_tick) begin
                case (r_mode)
                    MODE_WATER: begin
                        w_led_nxt = {r_led[2:0], r_led[3]};
                    end
                    MODE_PINGPONG: begin
                        w_pos_nxt = w_pos_step;
                        w_led_nxt = ~(4'b0001 << w_pos_step);
                        if (w_pos_step == 2'd3) begin
                            w_dir_up_nxt = 1'b0;
                        end else if (w_pos_step == 2'd0) begin
                            w_dir_up_nxt = 1'b1;
                        end
                    end
                    MODE_BLINK: begin
                        w_led_nxt = ~r_led;
                    end
                    default: begin
                        w_led_nxt = c_pat_off;
                    end
                endcase
            end
        end
    end

    assign led_out = r_led;
    assign mode    = r_mode;
    assign paused  = r_paused;

endmodule
`default_nettype wire

// File: doc/led_pattern_ctrl.md
LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

Interface
REQ-001 Parameter CNT_MAX, default 25'd24_999_999, is the terminal count of the step timer; one pattern step occurs every CNT_MAX+1 clocks (0.5 s at 50 MHz).
REQ-002 sys_clk  input  1  system clock; all state is updated on its rising edge.
REQ-003 sys_rst_n  input  1  asynchronous, active-low reset.
REQ-004 key_mode  input  1  single-cycle pulse from an already-debounced key; advances to the next mode.
REQ-005 key_pause  input  1  single-cycle pulse from an already-debounced key; toggles pause.
REQ-006 led_out  output  4  LED drive, active-low (0 = lit), registered.
REQ-007 mode  output  2  current mode: 0 OFF, 1 WATER, 2 PINGPONG, 3 BLINK; registered.
REQ-008 paused  output  1  high while stepping is frozen; registered.

Function
REQ-009 The mode FSM SHALL advance OFF->WATER->PINGPONG->BLINK->OFF on each key_mode pulse; mode updates on the clock edge that samples the pulse.
REQ-010 The step timer SHALL count 0..CNT_MAX, assert an internal tick while count==CNT_MAX, and wrap to 0 on the next clock.
REQ-011 On every mode change the timer SHALL clear to 0, paused SHALL clear, and led_out SHALL load the entry pattern on the same edge as mode.
REQ-012 Entry patterns SHALL be: OFF 4'b1111, WATER 4'b1110, PINGPONG 4'b1110 (position 0, direction up), BLINK 4'b0000.
REQ-013 In WATER, each tick SHALL rotate the lit LED upward: 1110->1101->1011->0111->1110.
REQ-014 In PINGPONG, each tick SHALL move the lit position by one in the current direction; direction flips on reaching position 3 or position 0, yielding positions 0,1,2,3,2,1,0,1,...
REQ-015 In BLINK, each tick SHALL invert all four bits of led_out.
REQ-016 In OFF, led_out SHALL stay 4'b1111 and the timer SHALL be held at 0.
REQ-017 key_pause SHALL toggle paused in WATER, PINGPONG and BLINK; it SHALL be ignored in OFF.
REQ-018 While paused, the timer SHALL hold its value, no tick SHALL occur, and led_out SHALL hold; on resume, counting continues from the held value.
REQ-019 key_mode and key_pause asserted in the same cycle: key_mode SHALL take effect and key_pause SHALL be discarded (paused ends at 0).
REQ-020 key_mode asserted on a tick cycle: the mode change SHALL take precedence and led_out SHALL take the new entry pattern, not a stepped pattern.
REQ-021 led_out SHALL change exactly one clock after the tick cycle; no combinational path from any input to any output.

Reset
REQ-022 While sys_rst_n is low, without waiting for a clock edge: led_out=4'b1111, mode=0, paused=0, timer=0, PINGPONG position=0, direction=up.
REQ-023 Reset asserted mid-operation in any mode SHALL abandon that mode; after release the block SHALL be in OFF until key_mode.

Structure
REQ-024 Mode encodings (OFF/WATER/PINGPONG/BLINK) and entry-pattern constants SHALL live in a shared package/header, led_pkg, for reuse by the other LED blocks.
REQ-025 The step timer SHALL be a separate sub-module, led_tick_gen, with ports sys_clk, sys_rst_n, clr, en, and tick, parameterised by CNT_MAX.
REQ-026 The FSM and pattern registers SHALL live in led_pattern_ctrl; total RTL of 120-400 lines.

Verification (bench uses CNT_MAX=24, so 25 clocks per step)
REQ-027 Reset held 3 clocks, then released with no keys -> led_out=1111, mode=0, paused=0 for 200 clocks.
REQ-028 One key_mode pulse -> next edge mode=1, led_out=1110; then 1101 at +25 clocks, 1011 at +50, 0111 at +75, 1110 at +100.
REQ-029 Two key_mode pulses -> mode=2; led_out sequence 1110,1101,1011,0111,1011,1101,1110,1101 at 25-clock intervals.
REQ-030 In WATER at 1101, key_pause at timer=10 -> led_out held and paused=1 for 300 clocks; second key_pause -> next step to 1011 arrives 15 clocks after resume.
REQ-031 key_mode+key_pause together in BLINK -> mode=0, led_out=1111, paused=0; and key_mode on a WATER tick cycle -> mode=2, led_out=1110.
REQ-032 sys_rst_n dropped mid-BLINK between clock edges -> led_out=1111 and mode=0 immediately, before the next rising edge.
